// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one 8N1 UART transmit line
// between NUM_REQ requesters. Contains its own baud counter and frame sequencer.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_FREQ  = 32_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int ID_W         = $clog2(NUM_REQ);
  // One extra bit so pointer + offset (at most 2*NUM_REQ-1) cannot overflow.
  localparam int SUM_W        = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_active_id;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_tx;
  logic               r_busy;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [SUM_W-1:0]   w_sum;
  logic [7:0]         w_byte;
  logic               w_bit_done;

  assign w_bit_done = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Round-robin winner: first set req bit scanning upward from r_ptr+1, wrapping.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(i + 1);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      if (!w_found && req[w_sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  // Byte of the current winner, taken from its slice of the flat data bus.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_byte = data[i*8 +: 8];
      end
    end
  end

  // Frame sequencer: arbitration in IDLE, then start, 8 data bits LSB first, stop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_active_id <= '0;
      r_grant     <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= NUM_REQ'(1) << w_winner;
            r_shift     <= w_byte;
            r_active_id <= w_winner;
            r_ptr       <= w_winner;
            r_busy      <= 1'b1;
            r_tx        <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // tx is registered, so it takes the bit that becomes shift[0].
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with CLKS_PER_BIT = 8. Expected (id, byte) pairs
// are queued when requests are raised and checked against each granted frame.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] val;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx;
  logic                 busy;
  logic [1:0]           active_id;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   last_grant;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CLK_FREQ (8),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .tx       (tx),
    .busy     (busy),
    .active_id(active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] val);
    exp_t e;
    e.id  = id;
    e.val = val;
    sb.push_back(e);
  endtask

  // Waits for a grant, checks it against the scoreboard head, then follows the
  // whole frame cycle by cycle. Returns on the first IDLE cycle after the frame.
  task automatic expect_frame(input logic [NUM_REQ-1:0] drop_mask, input bit chk_gap);
    exp_t       e;
    logic [7:0] rx;
    logic       exp_tx;
    int         t;
    int         wave_err;
    int         busy_err;
    t = 0;
    while (grant === '0 && t < 300) begin
      tick();
      t++;
    end
    check("grant_timeout", {31'b0, grant !== '0}, 32'd1);
    if (grant === '0) return;
    req = req & ~drop_mask;
    check("sb_level", {31'b0, sb.size() > 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (chk_gap) check("frame_gap", cyc - last_grant, 32'd81);
    last_grant = cyc;
    check("grant_onehot", {28'b0, grant}, 32'd1 << e.id);
    check("active_id", {30'b0, active_id}, {30'b0, e.id});
    wave_err = 0;
    busy_err = 0;
    rx       = '0;
    for (int off = 0; off < 10 * CPB; off++) begin
      if (off > 0) tick();
      if (off == 1) check("grant_pulse", {28'b0, grant}, 32'd0);
      if (off < CPB) exp_tx = 1'b0;
      else if (off < 9 * CPB) exp_tx = e.val[(off - CPB) / CPB];
      else exp_tx = 1'b1;
      if (tx !== exp_tx) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (off >= CPB && off < 9 * CPB && (off % CPB) == CPB / 2) rx[(off - CPB) / CPB] = tx;
    end
    check("tx_waveform_errs", wave_err, 32'd0);
    check("busy_low_in_frame", busy_err, 32'd0);
    check("rx_byte", {24'b0, rx}, {24'b0, e.val});
    tick();
    check("busy_end", {31'b0, busy}, 32'd0);
    check("tx_idle", {31'b0, tx}, 32'd1);
  endtask

  initial begin
    int t;
    int g_seen;
    int tx_bad;
    n_cmp      = 0;
    n_fail     = 0;
    cyc        = 0;
    last_grant = 0;
    rst        = 1'b1;
    req        = '0;
    data       = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_grant", {28'b0, grant}, 32'd0);
    check("rst_active_id", {30'b0, active_id}, 32'd0);
    rst = 1'b0;

    // Single request from requester 2.
    data[23:16] = 8'hA5;
    req         = 4'b0100;
    push(2'd2, 8'hA5);
    expect_frame(4'b0100, 1'b0);
    g_seen = 0;
    repeat (5) begin
      tick();
      if (grant !== '0 || busy !== 1'b0) g_seen++;
    end
    check("idle_quiet", g_seen, 32'd0);

    // All four held high: rotation 0,1,2,3,0 at 81-cycle spacing.
    do_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req  = 4'b1111;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    expect_frame(4'b0000, 1'b0);
    expect_frame(4'b0000, 1'b1);
    expect_frame(4'b0000, 1'b1);
    expect_frame(4'b0000, 1'b1);
    expect_frame(4'b1111, 1'b1);

    // Requester 1 just served: with 1 and 3 pending, 3 wins, then 1.
    data[15:8] = 8'h31;
    req        = 4'b0010;
    push(2'd1, 8'h31);
    expect_frame(4'b0010, 1'b0);
    data[15:8]  = 8'h32;
    data[31:24] = 8'h73;
    req         = 4'b1010;
    push(2'd3, 8'h73);
    push(2'd1, 8'h32);
    expect_frame(4'b1000, 1'b1);
    expect_frame(4'b0010, 1'b1);

    // req[0] pulsed and withdrawn during another frame: never granted.
    data[23:16] = 8'h5C;
    data[7:0]   = 8'hE1;
    req         = 4'b0100;
    push(2'd2, 8'h5C);
    fork
      expect_frame(4'b0100, 1'b1);
      begin
        repeat (20) tick();
        req[0] = 1'b1;
        repeat (10) tick();
        req[0] = 1'b0;
      end
    join
    g_seen = 0;
    tx_bad = 0;
    repeat (30) begin
      tick();
      if (grant !== '0) g_seen++;
      if (tx !== 1'b1) tx_bad++;
    end
    check("withdrawn_grant", g_seen, 32'd0);
    check("withdrawn_tx", tx_bad, 32'd0);

    // Reset at cycle 30 of a frame from requester 2.
    data[23:16] = 8'h77;
    req         = 4'b0100;
    t = 0;
    while (grant === '0 && t < 300) begin
      tick();
      t++;
    end
    check("rst_frame_grant", {28'b0, grant}, 32'b0100);
    req = '0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_grant", {28'b0, grant}, 32'd0);
    check("midrst_active_id", {30'b0, active_id}, 32'd0);
    rst       = 1'b0;
    data[7:0]   = 8'h0A;
    data[31:24] = 8'h3A;
    req       = 4'b1001;
    push(2'd0, 8'h0A);
    push(2'd3, 8'h3A);
    expect_frame(4'b0001, 1'b0);
    expect_frame(4'b1000, 1'b1);

    // data[1] changed mid-frame while req[1] held.
    data[15:8] = 8'h4D;
    req        = 4'b0010;
    push(2'd1, 8'h4D);
    push(2'd1, 8'hB2);
    fork
      expect_frame(4'b0000, 1'b0);
      begin
        repeat (40) tick();
        data[15:8] = 8'hB2;
      end
    join
    expect_frame(4'b0010, 1'b1);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
